seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream display stage: consumes the 8-bit count from the adder and drives a
//  4-digit multiplexed 7-segment display. Converts binary to 3-digit BCD with a
//  sequential shift-add-3 (double-dabble) FSM, then time-multiplexes digits via sel.
//  Digit 3 (leftmost) is always blank. Leading-zero blanking is optional.
// PARAMETERS
//  SCAN_DIV   50000  clk cycles per digit slot (>=2); full refresh = 4*SCAN_DIV
//  BLANK_LZ   1      1: blank leading zeros of hundreds/tens; 0: show all 3 digits
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst_n      in   1  asynchronous reset, active-low
//  value      in   8  unsigned binary to display (0..255)
//  sel        out  4  digit enable, active-low one-hot; sel[0] = units (rightmost)
//  digit      out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always off (1)
//  conv_done  out  1  1-cycle pulse: new BCD result written to display registers
// BEHAVIOUR
//  Reset (async, rst_n=0): sel=4'b1111, digit=8'hFF, conv_done=0, FSM=IDLE,
//   BCD display regs {hun,ten,uni}=0, slot counter=0, digit index=0.
//  Converter FSM, free-running, 10 cycles per conversion:
//   IDLE : capture value into shift reg, clear BCD work regs, shift_cnt=0 -> SHIFT
//   SHIFT: per cycle, each BCD nibble >=5 gets +3, then {bcd,bin} <<= 1;
//          shift_cnt++; after 8th shift -> DONE
//   DONE : copy work BCD to display regs, conv_done=1 for this cycle -> IDLE
//   value sampled in IDLE cycle N; display regs updated at end of cycle N+9;
//   conv_done high in cycle N+9. value changes during SHIFT/DONE are ignored
//   until next IDLE. Work nibbles never exceed 9 after DONE (max 255 -> 2,5,5).
//  Scan:
//   slot counter 0..SCAN_DIV-1, wraps to 0; on wrap digit index advances 0->1->2->3->0
//   and sel/digit are registered for the new index in that same edge.
//   First drive after reset: sel=4'b1110 (units) at cycle SCAN_DIV; until then blank.
//   sel/digit change ONLY on slot wrap (no mid-slot ghosting even if regs update).
//   Index 3: sel=4'b0111, digit=8'hFF (blank).
//   Index 2 (hundreds): blank if BLANK_LZ && hun==0.
//   Index 1 (tens): blank if BLANK_LZ && hun==0 && ten==0.
//   Index 0 (units): always shown (value 0 displays "0").
//   Segment codes (active-low, dp=1): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
//   Nibble >9 (unreachable) -> 8'hFF.
//  Reset mid-conversion or mid-slot: immediate return to reset state; no partial
//   result reaches display regs; scan restarts at slot 0, index 0.
// STRUCTURE
//  Shared package/header: SEG_* active-low segment constants (0-9, BLANK=8'hFF),
//   converter state encodings (ST_IDLE, ST_SHIFT, ST_DONE).
//  Sub-module bin2bcd_seq (value in, hun/ten/uni out, done pulse) holds the FSM;
//   top holds slot counter, digit index, blanking and segment decode.
// TESTING
//  1. rst_n=0 then release, value=0 -> sel=1111,digit=FF until cycle SCAN_DIV;
//     then units slot sel=1110,digit=C0; tens/hundreds slots digit=FF (BLANK_LZ=1).
//  2. value=8'd255 -> conv_done 10 cycles after IDLE capture; scan shows
//     units=92, tens=92, hundreds=A4, index 3 sel=0111 digit=FF.
//  3. value=8'd105, BLANK_LZ=1 -> hundreds=F9, tens=C0 (inner zero not blanked),
//     units=92; value=8'd7 -> tens and hundreds blank, units=F8.
//  4. Change value 100->200 during SHIFT -> first conv_done still reports 100,
//     next conversion reports 200; sel/digit never change off slot wrap.
//  5. Assert rst_n=0 at 3rd SHIFT cycle and at mid-slot -> outputs FF/1111
//     same cycle (async), no conv_done, display regs 0 after release.
//  6. SCAN_DIV=2: sel sequence 1110,1101,1011,0111,1110 every 2 cycles (wrap check).

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg: segment codes, converter states and digit helpers
package seg7_scan_driver_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} conv_state_t;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/seg7_scan_driver_bin2bcd.sv
// bin2bcd_seq: 10-cycle double-dabble converter with registered BCD result
module bin2bcd_seq
  import seg7_scan_driver_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  output logic [3:0] hun,
  output logic [3:0] ten,
  output logic [3:0] uni,
  output logic       done
);
  conv_state_t state, state_n;
  logic [7:0] sh, sh_n;
  logic [11:0] wb, wb_n, adj;
  logic [3:0] cnt, cnt_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sh <= '0;
      wb <= '0;
      cnt <= '0;
      {hun, ten, uni} <= '0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      wb <= wb_n;
      cnt <= cnt_n;
      if (state == ST_DONE) {hun, ten, uni} <= wb;
    end
  end
  always_comb begin
    state_n = state;
    sh_n = sh;
    wb_n = wb;
    cnt_n = cnt;
    done = 1'b0;
    adj = {add3(wb[11:8]), add3(wb[7:4]), add3(wb[3:0])};
    case (state)
      ST_IDLE: begin
        sh_n = value;
        wb_n = '0;
        cnt_n = '0;
        state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        {wb_n, sh_n} = {adj[10:0], sh, 1'b0};
        cnt_n = cnt + 4'd1;
        state_n = cnt == 4'd7 ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        done = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: BCD conversion plus 4-digit multiplexed active-low display scan
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  output logic [3:0] sel,
  output logic [7:0] digit,
  output logic       conv_done
);
  localparam int CW = SCAN_DIV > 2 ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [3:0] hun, ten, uni;
  logic [7:0] seg_n;
  logic wrap;
  bin2bcd_seq u_conv (
    .clk(clk),
    .rst_n(rst_n),
    .value(value),
    .hun(hun),
    .ten(ten),
    .uni(uni),
    .done(conv_done)
  );
  assign wrap = cnt == CW'(SCAN_DIV - 1);
  always_comb begin
    seg_n = idx == 2'd3 ? SEG_BLANK :
            idx == 2'd2 ? (BLANK_LZ && hun == 4'd0 ? SEG_BLANK : seg_of(hun)) :
            idx == 2'd1 ? (BLANK_LZ && hun == 4'd0 && ten == 4'd0 ? SEG_BLANK : seg_of(ten)) :
            seg_of(uni);
  end
  // idx names the digit driven at the next wrap, so units come up first after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      sel <= 4'b1111;
      digit <= SEG_BLANK;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        idx <= idx + 2'd1;
        sel <= ~(4'b0001 << idx);
        digit <= seg_n;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: random and directed stimulus against an arithmetic display model
module tb_seg7_scan_driver;
  localparam int SD1 = 4;
  localparam int SD2 = 2;
  localparam logic [7:0] SEGS [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                       8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [3:0] SELS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] value = 8'd0;
  logic [3:0] sel1, sel2;
  logic [7:0] digit1, digit2;
  logic done1, done2;
  int n_chk = 0;
  int n_pass = 0;
  int t = 0;
  int cap = 0;
  int disp = 0;
  logic [3:0] esel1 = 4'hF;
  logic [3:0] esel2 = 4'hF;
  logic [7:0] edig1 = 8'hFF;
  logic [7:0] edig2 = 8'hFF;
  always #5 clk = ~clk;
  seg7_scan_driver #(.SCAN_DIV(SD1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value),
    .sel(sel1), .digit(digit1), .conv_done(done1)
  );
  seg7_scan_driver #(.SCAN_DIV(SD2), .BLANK_LZ(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .value(value),
    .sel(sel2), .digit(digit2), .conv_done(done2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
  endtask
  function automatic logic [7:0] exp_digit(input int v, input int k, input bit lz);
    int h, te, u;
    h = v / 100;
    te = (v / 10) % 10;
    u = v % 10;
    if (k == 3) return 8'hFF;
    if (k == 2) return (lz && h == 0) ? 8'hFF : SEGS[h];
    if (k == 1) return (lz && v < 10) ? 8'hFF : SEGS[te];
    return SEGS[u];
  endfunction
  task automatic step();
    int k;
    @(negedge clk);
    check("conv_done1", done1, t % 10 == 9);
    check("conv_done2", done2, t % 10 == 9);
    check("sel1", sel1, esel1);
    check("digit1", digit1, edig1);
    check("sel2", sel2, esel2);
    check("digit2", digit2, edig2);
    @(posedge clk);
    if (t % 10 == 0) cap = value;
    if ((t + 1) % SD1 == 0) begin
      k = ((t + 1) / SD1 - 1) % 4;
      esel1 = SELS[k];
      edig1 = exp_digit(disp, k, 1'b1);
    end
    if ((t + 1) % SD2 == 0) begin
      k = ((t + 1) / SD2 - 1) % 4;
      esel2 = SELS[k];
      edig2 = exp_digit(disp, k, 1'b0);
    end
    if (t % 10 == 9) disp = cap;
    t++;
    #1;
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_sel1", sel1, 4'hF);
    check("rst_digit1", digit1, 8'hFF);
    check("rst_done1", done1, 1'b0);
    check("rst_sel2", sel2, 4'hF);
    check("rst_digit2", digit2, 8'hFF);
    check("rst_done2", done2, 1'b0);
    t = 0;
    cap = 0;
    disp = 0;
    esel1 = 4'hF;
    esel2 = 4'hF;
    edig1 = 8'hFF;
    edig2 = 8'hFF;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    value = 8'd0;
    repeat (24) step();
    value = 8'd255;
    repeat (60) step();
    value = 8'd105;
    repeat (60) step();
    value = 8'd7;
    repeat (60) step();
    while (t % 10 != 0) step();
    value = 8'd100;
    step();
    step();
    value = 8'd200;
    repeat (60) step();
    while (t % 10 != 3) step();
    do_reset();
    repeat (30) step();
    while (t % SD1 != 2) step();
    do_reset();
    repeat (30) step();
    repeat (40) begin
      value = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 40)) step();
      if ($urandom_range(0, 9) == 0) do_reset();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
